// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline types and constants.
// The IF/ID entry layout here is consumed directly by decode.
package rv32i_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        fault;
    } if_id_t;

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter with next-PC selection: redirect, then stall, then +4.
// Misaligned redirect targets are loaded unchanged; faults are flagged downstream.
module pc_reg
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc_q
);

    logic [31:0] pc_d;

    always_comb begin
        pc_d = pc_inc(pc_q);
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (stall) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, drives the zero-latency instruction
// memory and registers the fetched word into IF/ID with fault and count tracking.
module if_stage
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          IMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall_f,
    input  logic        flush_d,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        id_fault,
    output logic [31:0] fetch_count
);

    localparam logic [29:0] IMEM_LIMIT = 30'(IMEM_WORDS);
    localparam if_id_t ID_RESET = '{valid: 1'b0, instr: NOP_INSTR, pc: 32'h0,
                                    pc_plus4: 32'h0, fault: 1'b0};

    logic [31:0] pc_q;
    logic [31:0] count_q;
    logic        accept;
    logic        fault;
    if_id_t      id_q;
    if_id_t      id_d;

    pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall_f),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .pc_q          (pc_q)
    );

    assign imem_addr = pc_q;
    assign fault     = (pc_q[1:0] != 2'b00) || (pc_q[31:2] >= IMEM_LIMIT);

    // A bubble keeps the old pc fields so decode still sees a coherent entry.
    always_comb begin
        id_d   = id_q;
        accept = 1'b0;
        if (redirect_valid || flush_d) begin
            id_d.valid = 1'b0;
            id_d.instr = NOP_INSTR;
            id_d.fault = 1'b0;
        end else if (!stall_f) begin
            id_d.valid    = 1'b1;
            id_d.instr    = imem_rdata;
            id_d.pc       = pc_q;
            id_d.pc_plus4 = pc_inc(pc_q);
            id_d.fault    = fault;
            accept        = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q    <= ID_RESET;
            count_q <= 32'h0;
        end else begin
            id_q <= id_d;
            if (accept) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    assign id_valid    = id_q.valid;
    assign id_instr    = id_q.instr;
    assign id_pc       = id_q.pc;
    assign id_pc_plus4 = id_q.pc_plus4;
    assign id_fault    = id_q.fault;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a reference model predicts each IF/ID entry
// when stimulus is driven and the prediction is compared after the edge.
module tb_if_stage;
    import rv32i_pkg::*;

    typedef struct {
        if_id_t      id;
        logic [31:0] cnt;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr, imem_rdata;
    logic        stall_f, flush_d, redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid, id_fault;
    logic [31:0] id_instr, id_pc, id_pc_plus4, fetch_count;

    logic [31:0] imem_addr_w, imem_rdata_w;
    logic        id_valid_w, id_fault_w;
    logic [31:0] id_instr_w, id_pc_w, id_pc_plus4_w, fetch_count_w;

    logic [31:0] mem [64];
    exp_t        sb_q[$];
    int          total = 0;
    int          bad   = 0;

    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    if_id_t      m_id;

    always #5 clk = ~clk;

    assign imem_rdata   = mem[imem_addr[7:2]];
    assign imem_rdata_w = mem[imem_addr_w[7:2]];

    if_stage dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .stall_f(stall_f), .flush_d(flush_d), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .id_valid(id_valid), .id_instr(id_instr),
        .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .id_fault(id_fault),
        .fetch_count(fetch_count)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC), .IMEM_WORDS(64)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr_w), .imem_rdata(imem_rdata_w),
        .stall_f(1'b0), .flush_d(1'b0), .redirect_valid(1'b0),
        .redirect_pc(32'h0), .id_valid(id_valid_w), .id_instr(id_instr_w),
        .id_pc(id_pc_w), .id_pc_plus4(id_pc_plus4_w), .id_fault(id_fault_w),
        .fetch_count(fetch_count_w)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc  = 32'h0;
        m_cnt = 32'h0;
        m_id  = '{valid: 1'b0, instr: 32'h0000_0013, pc: 32'h0, pc_plus4: 32'h0, fault: 1'b0};
    endtask

    // Drive one cycle of stimulus, predict the result, then check after the edge.
    task automatic step(input logic st, input logic fl, input logic rv, input logic [31:0] rpc);
        exp_t e;
        stall_f        = st;
        flush_d        = fl;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if (rv || fl) begin
            m_id.valid = 1'b0;
            m_id.instr = 32'h0000_0013;
            m_id.fault = 1'b0;
        end else if (!st) begin
            m_id.valid    = 1'b1;
            m_id.instr    = mem[m_pc[7:2]];
            m_id.pc       = m_pc;
            m_id.pc_plus4 = m_pc + 32'd4;
            m_id.fault    = (m_pc[1:0] != 2'b00) || (m_pc >= 32'd256);
            m_cnt         = m_cnt + 32'd1;
        end
        m_pc = rv ? rpc : (st ? m_pc : m_pc + 32'd4);
        e.id  = m_id;
        e.cnt = m_cnt;
        e.pc  = m_pc;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("id_valid", {31'b0, id_valid}, {31'b0, e.id.valid});
        chk("id_instr", id_instr, e.id.instr);
        chk("id_pc", id_pc, e.id.pc);
        chk("id_pc_plus4", id_pc_plus4, e.id.pc_plus4);
        chk("id_fault", {31'b0, id_fault}, {31'b0, e.id.fault});
        chk("fetch_count", fetch_count, e.cnt);
        chk("imem_addr", imem_addr, e.pc);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | (i << 8) | 32'h13;
        mem[0] = 32'h0050_0113;
        mem[1] = 32'h00C0_0193;
        mem[2] = 32'hFF71_8393;
        mem[3] = 32'h0023_E233;
        stall_f = 0; flush_d = 0; redirect_valid = 0; redirect_pc = 0;
        rst_n = 1'b0;
        model_reset();
        #12;
        chk("rst_valid", {31'b0, id_valid}, 32'h0);
        chk("rst_instr", id_instr, 32'h0000_0013);
        chk("rst_count", fetch_count, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_addr_wrap", imem_addr_w, 32'hFFFF_FFFC);
        #10 rst_n = 1'b1;

        // sequential fetch of words 0..3; the first step also checks the wrapping instance
        step(0, 0, 0, 0);
        chk("wrap_pc_next", imem_addr_w, 32'h0);
        chk("wrap_id_pc", id_pc_w, 32'hFFFF_FFFC);
        chk("wrap_pc_plus4", id_pc_plus4_w, 32'h0);
        chk("wrap_fault", {31'b0, id_fault_w}, 32'h1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("seq_id_pc8", id_pc, 32'h8);
        step(0, 0, 0, 0);
        chk("seq_count4", fetch_count, 32'd4);

        // load-use stall; redo the stall from id_pc=8 by redirecting back
        step(0, 0, 1, 32'h8);
        step(0, 0, 0, 0);
        chk("pre_stall_id_pc", id_pc, 32'h8);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("stall_id_pc", id_pc, 32'h8);
        chk("stall_addr", imem_addr, 32'hC);
        step(0, 0, 0, 0);
        chk("post_stall_id_pc", id_pc, 32'hC);

        // advance to pc=0x24 and branch to 0x28
        while (m_pc != 32'h24) step(0, 0, 0, 0);
        step(0, 0, 1, 32'h28);
        chk("br_bubble", {31'b0, id_valid}, 32'h0);
        step(0, 0, 0, 0);
        chk("br_target", id_pc, 32'h28);

        step(1, 0, 1, 32'h44);
        chk("rs_addr", imem_addr, 32'h44);
        step(0, 0, 0, 0);

        step(0, 0, 1, 32'h46);
        step(0, 0, 0, 0);
        chk("mis_fault", {31'b0, id_fault}, 32'h1);
        chk("mis_pc", id_pc, 32'h46);
        step(0, 0, 0, 0);
        step(0, 0, 1, 32'h100);
        step(0, 0, 0, 0);
        chk("oor_fault", {31'b0, id_fault}, 32'h1);

        step(0, 0, 1, 32'h10);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);

        for (int i = 0; i < 60; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 6) == 0, {24'h0, 6'($urandom_range(0, 63)), 2'b00});
        end

        // asynchronous reset in the middle of a cycle
        step(0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", {31'b0, id_valid}, 32'h0);
        chk("async_count", fetch_count, 32'h0);
        chk("async_addr", imem_addr, 32'h0);
        model_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
